// File: rtl/grid_mem_arbiter.sv
// Round-robin arbiter for the single port of the 32x24 grid-cell RAM, with a
// clear engine that sweeps NULL into every cell after reset and on clear_start.
module grid_mem_arbiter #(
  parameter int NREQ   = 3,
  parameter int GRID_X = 32,
  parameter int GRID_Y = 24,
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int AW     = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_start,
  output logic                 clear_busy,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*XW-1:0]   x_in,
  input  logic [NREQ*YW-1:0]   y_in,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      err,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int NCELL = GRID_X * GRID_Y;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] rvalid_q;

  logic            found;
  logic [PW-1:0]   win;
  logic            fire;
  logic [NREQ-1:0] win_vec;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;
  logic            range_err;

  // Search starts one past the last winner so a held request waits its turn.
  always_comb begin : pick
    int cand;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  always_comb begin
    sel_x     = x_in[int'(win)*XW +: XW];
    sel_y     = y_in[int'(win)*YW +: YW];
    sel_wdata = wdata[int'(win)*DW +: DW];
    sel_we    = we[win];
    range_err = (int'(sel_x) >= GRID_X) || (int'(sel_y) >= GRID_Y);
    fire      = (state == SERVE) && !clear_start && found;
    win_vec   = fire ? (NREQ'(1) << win) : '0;
  end

  assign gnt        = win_vec;
  assign err        = range_err ? win_vec : '0;
  assign rvalid     = rvalid_q;
  assign rdata      = (|rvalid_q) ? mem_rdata : '0;
  assign clear_busy = (state == CLEAR);

  // The sweep port drive is masked while rst is held so the RAM sees no writes in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_en   = !rst;
      mem_we   = !rst;
      mem_addr = rst ? '0 : clr_cnt;
    end else if (fire && !range_err) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_addr  = AW'(int'(sel_y) * GRID_X + int'(sel_x));
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ptr      <= PW'(NREQ - 1);
      rvalid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      rvalid_q <= '0;
      case (state)
        CLEAR: begin
          if (clr_cnt == AW'(NCELL - 1)) begin
            state   <= SERVE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        SERVE: begin
          if (clear_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (found) begin
            ptr <= win;
            if (!range_err && !sel_we) rvalid_q <= win_vec;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter: clear sweep, round-robin, reads,
// range errors, clear preemption and reset in the middle of activity.
module tb_grid_mem_arbiter;

  localparam int NCELL = 768;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_start;
  logic        clear_busy;
  logic [2:0]  req, we, gnt, err, rvalid;
  logic [14:0] x_in, y_in;
  logic [11:0] wdata;
  logic [3:0]  rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;

  int n_vec = 0;
  int n_bad = 0;

  grid_mem_arbiter dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
    .req(req), .we(we), .x_in(x_in), .y_in(y_in), .wdata(wdata),
    .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view: gnt, err, rvalid, clear_busy, mem_en, mem_we, mem_wdata, mem_addr.
  task automatic chk_bus(input string tag, input logic [2:0] g, input logic [2:0] e,
                         input logic [2:0] rv, input logic busy, input logic en,
                         input logic w, input logic [9:0] a, input logic [3:0] d);
    chk(tag, {gnt, err, rvalid, clear_busy, mem_en, mem_we, mem_wdata, mem_addr},
        {g, e, rv, busy, en, w, d, a});
  endtask

  task automatic set_port(input int p, input logic [4:0] x, input logic [4:0] y,
                          input logic [3:0] d);
    x_in[p*5 +: 5]  = x;
    y_in[p*5 +: 5]  = y;
    wdata[p*4 +: 4] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear_start = 1'b0; req = '0; we = '0;
    x_in = '0; y_in = '0; wdata = '0; mem_rdata = '0;
    step(); step(); #1;

    // Reset values.
    chk_bus("reset_outputs", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
    chk("reset_rdata", rdata, 4'd0);

    // Test 1: full sweep, no grants, then clear_busy falls.
    step(); rst = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      #1 chk_bus($sformatf("sweep1_%0d", i), 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1,
                 10'(i), 4'd0);
      step();
    end
    #1 chk_bus("sweep1_done", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0);

    // Test 2: all three ports write, held request rotates 0,1,2,0,...
    set_port(0, 5'd1, 5'd0, 4'd2);     // addr 1
    set_port(1, 5'd2, 5'd1, 4'd3);     // addr 34
    set_port(2, 5'd31, 5'd23, 4'd4);   // addr 767
    req = 3'b111; we = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 case (i % 3)
        0: chk_bus($sformatf("rr_%0d", i), 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 10'd1, 4'd2);
        1: chk_bus($sformatf("rr_%0d", i), 3'b010, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 10'd34, 4'd3);
        default: chk_bus($sformatf("rr_%0d", i), 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 10'd767, 4'd4);
      endcase
      step();
    end

    // Test 3: port 2 read at (15,15) -> addr 495, data back one cycle later.
    set_port(2, 5'd15, 5'd15, 4'd0);
    req = 3'b100; we = 3'b000; mem_rdata = 4'd1;
    #1 chk_bus("rd2_gnt", 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 10'd495, 4'd0);
    step(); req = 3'b000;
    #1 chk_bus("rd2_rvalid", 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0);
    chk("rd2_rdata", rdata, 4'd1);
    step();
    #1 chk("rd2_rvalid_pulse", rvalid, 3'b000);

    // Test 4: port 1 with y out of range: gnt+err, no RAM access, no rvalid.
    set_port(1, 5'd3, 5'd24, 4'd0);
    req = 3'b010;
    #1 chk_bus("err1_gnt", 3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0);
    step(); req = 3'b000;
    #1 chk("err1_no_rvalid", rvalid, 3'b000);
    step();

    // Pointer advanced past port 1, so port 2 wins next; reads then pipeline.
    set_port(0, 5'd1, 5'd0, 4'd0);     // addr 1
    set_port(1, 5'd0, 5'd0, 4'd0);     // addr 0
    req = 3'b111; mem_rdata = 4'd0;
    #1 chk_bus("after_err_p2", 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 10'd495, 4'd0);
    step(); mem_rdata = 4'd9;
    #1 chk_bus("pipe_p0", 3'b001, 3'b000, 3'b100, 1'b0, 1'b1, 1'b0, 10'd1, 4'd0);
    chk("pipe_p2_rdata", rdata, 4'd9);
    step(); mem_rdata = 4'd6;
    #1 chk_bus("pipe_p1", 3'b010, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 10'd0, 4'd0);
    chk("pipe_p0_rdata", rdata, 4'd6);

    // clear_start right after a read grant: no grant now, pending rvalid still returns.
    step(); mem_rdata = 4'd7; clear_start = 1'b1;
    #1 chk_bus("clr_start", 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0);
    chk("clr_start_rdata", rdata, 4'd7);

    // Test 5: port 0 held through the sweep; a second clear_start is ignored.
    step(); clear_start = 1'b0; req = 3'b001; we = 3'b001; set_port(0, 5'd1, 5'd0, 4'd5);
    for (int i = 0; i < NCELL; i++) begin
      clear_start = (i == 100);
      #1 chk_bus($sformatf("sweep5_%0d", i), 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1,
                 10'(i), 4'd0);
      step();
    end
    clear_start = 1'b0;
    #1 chk_bus("sweep5_gnt0", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 10'd1, 4'd5);
    step();

    // Test 6a: reset while a read is outstanding -> no rvalid.
    req = 3'b100; we = 3'b000;
    #1 chk("rst_rd_gnt", gnt, 3'b100);
    #1 rst = 1'b1;
    step(); req = 3'b000;
    #1 chk_bus("rst_rd_outputs", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
    chk("rst_rd_rdata", rdata, 4'd0);

    // Test 6b: reset at clear count 300, sweep restarts at 0.
    step(); rst = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      #1 chk_bus($sformatf("sweep6_%0d", i), 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1,
                 10'(i), 4'd0);
      if (i < 300) step();
    end
    rst = 1'b1;
    #1 chk_bus("rst_mid_outputs", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 10'd0, 4'd0);
    step(); rst = 1'b0;
    req = 3'b111; we = 3'b111;
    set_port(1, 5'd2, 5'd1, 4'd3);
    set_port(2, 5'd31, 5'd23, 4'd4);
    for (int i = 0; i < NCELL; i++) begin
      #1 chk_bus($sformatf("sweep7_%0d", i), 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1,
                 10'(i), 4'd0);
      step();
    end
    // Pointer reset to NREQ-1, so port 0 wins first again.
    #1 chk_bus("post_rst_gnt0", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 10'd1, 4'd5);
    step(); req = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
